// File: rtl/z_pulse_monitor.sv
// z_pulse_monitor: samples the detector's z output over fixed-length windows of
// enabled cycles. For each window it accumulates the number of z-high samples
// and the longest consecutive z-high run, then presents the result on a
// valid/ready interface. A window result that arrives while the previous one is
// still unaccepted is discarded and the sticky `dropped` flag is raised.
`timescale 1ns/1ps

module z_pulse_monitor #(
  parameter int WIN = 16,  // window length in enabled cycles (>= 2)
  parameter int CW  = 8    // width of count / max_run, saturating
) (
  input  logic          clk,
  input  logic          reset,      // synchronous, active-low
  input  logic          en,
  input  logic          z,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] count,
  output logic [CW-1:0] max_run,
  output logic          sat,
  output logic          dropped
);

  localparam int          WW   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CW-1:0] MAXV = '1;
  localparam logic [WW-1:0] LAST = WW'(WIN - 1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // Window accumulators
  logic [WW-1:0] r_wcnt;
  logic [CW-1:0] r_acc;
  logic [CW-1:0] r_run;
  logic [CW-1:0] r_maxr;
  logic          r_sat_acc;

  // Result registers and output FSM
  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_max_run;
  logic          r_sat;
  logic          r_dropped;

  // Values the accumulators take after this cycle's sample
  logic          w_win_end;
  logic [CW-1:0] w_acc_nxt;
  logic [CW-1:0] w_run_nxt;
  logic [CW-1:0] w_maxr_nxt;
  logic          w_sat_nxt;
  logic          w_load;
  logic          w_drop;

  assign w_win_end = en && (r_wcnt == LAST);

  // Next accumulator values including the current sample, with saturation
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    w_acc_nxt = r_acc;
    w_run_nxt = '0;
    if (z) begin
      w_acc_nxt = (r_acc == MAXV) ? MAXV : r_acc + 1'b1;
      w_run_nxt = (r_run == MAXV) ? MAXV : r_run + 1'b1;
    end
    w_maxr_nxt = (w_run_nxt > r_maxr) ? w_run_nxt : r_maxr;
    w_sat_nxt  = r_sat_acc || (z && ((w_acc_nxt == MAXV) || (w_run_nxt == MAXV)));
  end

  // Window counter and accumulators; cleared at window end so the next
  // enabled cycle starts a fresh window with no gap
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      r_wcnt    <= '0;
      r_acc     <= '0;
      r_run     <= '0;
      r_maxr    <= '0;
      r_sat_acc <= 1'b0;
    end else if (en) begin
      if (w_win_end) begin
        r_wcnt    <= '0;
        r_acc     <= '0;
        r_run     <= '0;
        r_maxr    <= '0;
        r_sat_acc <= 1'b0;
      end else begin
        r_wcnt    <= r_wcnt + 1'b1;
        r_acc     <= w_acc_nxt;
        r_run     <= w_run_nxt;
        r_maxr    <= w_maxr_nxt;
        r_sat_acc <= w_sat_nxt;
      end
    end
  end

  // Output FSM next state: decides whether a finished window is loaded or dropped
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_win_end) begin
          w_load      = 1'b1;
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_win_end) begin
          // Back-to-back accept and reload keeps out_valid high with no bubble
          if (out_ready) w_load = 1'b1;
          else           w_drop = 1'b1;
        end else if (out_ready) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Output FSM state, result registers and sticky drop flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_EMPTY;
      r_count   <= '0;
      r_max_run <= '0;
      r_sat     <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_count   <= w_acc_nxt;
        r_max_run <= w_maxr_nxt;
        r_sat     <= w_sat_nxt;
      end
      if (w_drop) r_dropped <= 1'b1;
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign count     = r_count;
  assign max_run   = r_max_run;
  assign sat       = r_sat;
  assign dropped   = r_dropped;

endmodule
